jt6295_acc_ip: RTL and testbench

Multi-channel successor to the single-channel ADPCM output accumulator in the JT6295 sound path. For each of CH channels it integrates the decoder output over one sample frame (all `cen4` strobes from one `cen` to the next). It saturates each sum to the output width and emits a UP× upsampled stream through a sequential linear interpolator. It sits between the ADPCM voice mixer and the JTFRAME audio mixer; no external FIR is required.

---
 rtl/jt6295_acc_ip.sv | 156 +++++++++++++++
 tb/tb_jt6295_acc_ip.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_acc_ip.sv
// rtl/jt6295_acc_ip.sv - multi-channel ADPCM frame accumulator with saturation and optional linear upsampling (macro JT6295_ACC_INTERP_EN)
`timescale 1ns/1ps
module jt6295_acc_ip #(
    parameter int CH    = 2,
    parameter int DW    = 12,
    parameter int OW    = 14,
    parameter int UPLOG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             cen4,
    input  logic [CH*DW-1:0] sound_in,
    input  logic             clip_clr,
    output logic [CH*OW-1:0] sound_out,
    output logic             sample,
    output logic [CH-1:0]    clip
);
    // frame boundary and in-frame sub-sample strobes; cen alone is ignored
    logic          w_frame;
    logic          w_step;
    logic [CH-1:0] w_clamp;
    logic [CH-1:0] r_clip;
    logic          r_sample;

    assign w_frame = cen4 & cen;
    assign w_step  = cen4 & ~cen;

`ifdef JT6295_ACC_INTERP_EN
    localparam int UP = 1 << UPLOG;

    logic [UPLOG-1:0] r_k;
    logic             w_kadv;

    // ramp advances until the last step of the frame, then holds for long frames
    assign w_kadv = w_step & (r_k != UPLOG'(UP - 1));

    // shared interpolation step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_k <= '0;
        else if (w_frame) r_k <= '0;
        else if (w_kadv)  r_k <= r_k + 1'b1;
    end

    // a new interpolated value is produced on every sub-sample strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sample <= 1'b0;
        else     r_sample <= cen4;
    end
`else
    // without interpolation only the frame value is refreshed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sample <= 1'b0;
        else     r_sample <= w_frame;
    end
`endif

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DW-1:0] w_in;
        logic signed [OW:0]   w_in_x;
        logic signed [OW:0]   w_sum;
        logic signed [OW-1:0] w_sat;
        logic                 w_pos_ovf;
        logic                 w_neg_ovf;
        logic signed [OW-1:0] r_acc;
        logic signed [OW-1:0] r_cur;

        assign w_in      = sound_in[c*DW +: DW];
        assign w_in_x    = {{(OW + 1 - DW){w_in[DW-1]}}, w_in};
        assign w_sum     = {r_acc[OW-1], r_acc} + w_in_x;
        assign w_pos_ovf = ~w_sum[OW] &  w_sum[OW-1];
        assign w_neg_ovf =  w_sum[OW] & ~w_sum[OW-1];
        assign w_clamp[c] = w_pos_ovf | w_neg_ovf;

        // clamp the running sum to the signed output range
        always_comb begin
            w_sat = w_sum[OW-1:0];
            if (w_pos_ovf)      w_sat = {1'b0, {(OW - 1){1'b1}}};
            else if (w_neg_ovf) w_sat = {1'b1, {(OW - 1){1'b0}}};
        end

        // frame integrator; the closing sum moves to cur when the next frame opens
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
                r_cur <= '0;
            end else if (w_frame) begin
                r_acc <= w_in_x[OW-1:0];
                r_cur <= r_acc;
            end else if (w_step) begin
                r_acc <= w_sat;
            end
        end

`ifdef JT6295_ACC_INTERP_EN
        localparam int RW = OW + 1 + UPLOG;

        logic signed [OW-1:0] r_prev;
        logic signed [OW-1:0] r_out;
        logic signed [OW:0]   r_delta;
        logic signed [RW-1:0] r_ramp;
        logic signed [OW-1:0] w_prev_n;
        logic signed [RW-1:0] w_ramp_n;
        logic signed [RW-1:0] w_ramp_sh;
        logic signed [RW-1:0] w_out_full;
        logic                 w_unused_hi;

        // next prev/ramp, so the registered output reflects the state after this strobe
        always_comb begin
            w_prev_n = r_prev;
            w_ramp_n = r_ramp;
            if (w_frame) begin
                w_prev_n = r_cur;
                w_ramp_n = '0;
            end else if (w_kadv) begin
                w_ramp_n = r_ramp + {{UPLOG{r_delta[OW]}}, r_delta};
            end
        end

        // floor division of the ramp keeps the output between prev and cur
        assign w_ramp_sh   = w_ramp_n >>> UPLOG;
        assign w_out_full  = {{(UPLOG + 1){w_prev_n[OW-1]}}, w_prev_n} + w_ramp_sh;
        assign w_unused_hi = ^w_out_full[RW-1:OW];

        // interpolator state and output register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prev  <= '0;
                r_delta <= '0;
                r_ramp  <= '0;
                r_out   <= '0;
            end else begin
                if (w_frame) r_delta <= {r_acc[OW-1], r_acc} - {r_cur[OW-1], r_cur};
                if (cen4) begin
                    r_prev <= w_prev_n;
                    r_ramp <= w_ramp_n;
                    r_out  <= w_out_full[OW-1:0];
                end
            end
        end

        assign sound_out[c*OW +: OW] = r_out;
`else
        assign sound_out[c*OW +: OW] = r_cur;
`endif
    end

    // sticky clip flags; a clamp in the same cycle as clip_clr keeps its flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_clip <= '0;
        else     r_clip <= (w_clamp & {CH{w_step}}) | (r_clip & ~{CH{clip_clr}});
    end

    assign clip   = r_clip;
    assign sample = r_sample;
endmodule

// File: tb/tb_jt6295_acc_ip.sv
// tb/tb_jt6295_acc_ip.sv - scoreboard bench for jt6295_acc_ip
`timescale 1ns/1ps
module tb_jt6295_acc_ip;
    localparam int CH    = 2;
    localparam int DW    = 12;
    localparam int OW    = 14;
    localparam int UPLOG = 2;
    localparam int UP    = 4;
    localparam int SMAX  = 8191;
    localparam int SMIN  = -8192;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             cen      = 1'b0;
    logic             cen4     = 1'b0;
    logic             clip_clr = 1'b0;
    logic [CH*DW-1:0] sound_in = '0;
    logic [CH*OW-1:0] sound_out;
    logic             sample;
    logic [CH-1:0]    clip;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int v0;
        int v1;
        int cl;
    } exp_t;
    exp_t sbq[$];

    int m_acc[CH];
    int m_cur[CH];
    int m_prev[CH];
    int m_delta[CH];
    int m_ramp[CH];
    int m_k;
    int m_clip;

    always #5 clk = ~clk;

    jt6295_acc_ip #(.CH(CH), .DW(DW), .OW(OW), .UPLOG(UPLOG)) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cen4     (cen4),
        .sound_in (sound_in),
        .clip_clr (clip_clr),
        .sound_out(sound_out),
        .sample   (sample),
        .clip     (clip)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0; m_cur[c] = 0; m_prev[c] = 0; m_delta[c] = 0; m_ramp[c] = 0;
        end
        m_k    = 0;
        m_clip = 0;
    endtask

    // one cen4 strobe: update the reference model, push the expectation, drive the DUT
    task automatic strobe(input bit f, input int a0, input int a1, input bit clr = 1'b0);
        int in[CH];
        int s;
        int clamp;
        bit kadv;
        logic [DW-1:0] s0;
        logic [DW-1:0] s1;
        s0 = a0[DW-1:0];
        s1 = a1[DW-1:0];
        in[0] = a0;
        in[1] = a1;
        clamp = 0;
        kadv  = !f && (m_k < UP - 1);
        for (int c = 0; c < CH; c++) begin
            if (f) begin
                m_delta[c] = m_acc[c] - m_cur[c];
                m_prev[c]  = m_cur[c];
                m_cur[c]   = m_acc[c];
                m_ramp[c]  = 0;
                m_acc[c]   = in[c];
            end else begin
                s = m_acc[c] + in[c];
                if (s > SMAX) begin
                    s = SMAX;
                    clamp |= (1 << c);
                end else if (s < SMIN) begin
                    s = SMIN;
                    clamp |= (1 << c);
                end
                m_acc[c] = s;
                if (kadv) m_ramp[c] += m_delta[c];
            end
        end
        m_clip = clamp | (clr ? 0 : m_clip);
        if (f) m_k = 0;
        else if (kadv) m_k++;
`ifdef JT6295_ACC_INTERP_EN
        sbq.push_back('{m_prev[0] + (m_ramp[0] >>> UPLOG), m_prev[1] + (m_ramp[1] >>> UPLOG), m_clip});
`else
        if (f) sbq.push_back('{m_cur[0], m_cur[1], m_clip});
`endif
        cen4     = 1'b1;
        cen      = f;
        clip_clr = clr;
        sound_in = {s1, s0};
        @(posedge clk);
        #1;
        cen4     = 1'b0;
        cen      = 1'b0;
        clip_clr = 1'b0;
    endtask

    task automatic frame(input int n, input int a0, input int a1);
        strobe(1'b1, a0, a1);
        for (int i = 1; i < n; i++) strobe(1'b0, a0, a1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard consumer: every sample pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample === 1'b1) begin
                check("sample_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("out_ch0", $signed(sound_out[OW-1:0]), e.v0);
                    check("out_ch1", $signed(sound_out[2*OW-1:OW]), e.v1);
                    check("clip_at_sample", {30'd0, clip}, e.cl);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #12;
        check("rst_sound_out", {4'd0, sound_out}, 0);
        check("rst_sample", {31'd0, sample}, 0);
        check("rst_clip", {30'd0, clip}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // constant inputs
        repeat (3) frame(UP, 100, -50);
        check("const_ch0", $signed(sound_out[OW-1:0]), 400);
        check("const_ch1", $signed(sound_out[2*OW-1:OW]), -200);
        check("const_clip", {30'd0, clip}, 0);

        // step 0 -> 400 on ch0, with a gapped frame and a lone cen
        frame(UP, 0, -50);
        strobe(1'b1, 100, 0);
        idle(2);
        strobe(1'b0, 100, 0);
        cen = 1'b1;
        @(posedge clk);
        #1;
        cen = 1'b0;
        strobe(1'b0, 100, 0);
        idle(1);
        strobe(1'b0, 100, 0);
        frame(UP, 0, 7);

        // negative fractional ramp 0 -> -3
        frame(UP, 0, 0);
        strobe(1'b1, -3, 1);
        repeat (UP - 1) strobe(1'b0, 0, 0);
        frame(UP, 0, 0);
        strobe(1'b1, 0, 0);
        repeat (UP - 1) strobe(1'b0, 0, 0);

        // saturation on both channels
        frame(UP + 1, 2047, -2048);
        check("clip_set", {30'd0, clip}, 3);
        clip_clr = 1'b1;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
        m_clip   = 0;
        check("clip_cleared", {30'd0, clip}, 0);
        strobe(1'b1, 2047, -2048);
        repeat (UP - 1) strobe(1'b0, 2047, -2048);
        strobe(1'b0, 2047, -2048, 1'b1);
        check("clip_set_wins", {30'd0, clip}, 3);
        frame(UP, 0, 0);
        check("sat_acc_ch0_cur", m_cur[0], SMAX);

        // long frame after 0 -> 400
        frame(UP, 0, 0);
        frame(UP, 100, 25);
        frame(UP + 2, 0, 0);
        strobe(1'b1, 0, 0);

        // reset in the middle of a ramp (k = 2)
        frame(UP, 100, -50);
        strobe(1'b1, 0, 0);
        strobe(1'b0, 0, 0);
        strobe(1'b0, 0, 0);
        rst = 1'b1;
        #1;
        check("midrst_sound_out", {4'd0, sound_out}, 0);
        check("midrst_sample", {31'd0, sample}, 0);
        check("midrst_clip", {30'd0, clip}, 0);
        sbq.delete();
        model_reset();
        idle(2);
        rst = 1'b0;
        repeat (3) frame(UP, 100, -50);
        strobe(1'b1, 0, 0);
        idle(3);

        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
